// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
//   Shares one combinational ALU between NREQ requesters. A round-robin grant
//   picks one valid requester per IDLE cycle. Its operands are registered onto
//   the ALU drive. The result comes back one cycle later and is returned on a
//   single registered response channel, tagged with the requester id.
//   Divide (opcode 3) by zero is detected here and forced to all-ones with rsp_dz.
// Ports
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         per-requester handshake (ready one-hot or zero)
//   req_a/req_b/req_op          packed per-requester operands/opcode
//   alu_a/alu_b/alu_opcode      registered ALU drive
//   alu_out                     ALU result
//   rsp_valid/rsp_ready         response handshake
//   rsp_data/rsp_id/rsp_dz      result, requester id, divide-by-zero flag

// Per-requester operand gate: contributes its operands only when granted,
// so the top can OR-reduce all lanes into a one-hot mux.
module alu_req_arbiter_lane #(
  parameter int DW  = 8,
  parameter int OPW = 4
) (
  input  logic           gnt_i,
  input  logic [DW-1:0]  a_i,
  input  logic [DW-1:0]  b_i,
  input  logic [OPW-1:0] op_i,
  output logic [DW-1:0]  a_o,
  output logic [DW-1:0]  b_o,
  output logic [OPW-1:0] op_o
);
  assign a_o  = gnt_i ? a_i  : '0;
  assign b_o  = gnt_i ? b_i  : '0;
  assign op_o = gnt_i ? op_i : '0;
endmodule

module alu_req_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int OPW  = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*DW-1:0]  req_a,
  input  logic [NREQ*DW-1:0]  req_b,
  input  logic [NREQ*OPW-1:0] req_op,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic [OPW-1:0]    alu_opcode,
  input  logic [DW-1:0]     alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_dz
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [DW-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OPW-1:0]  alu_op_q, alu_op_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic            rsp_dz_q, rsp_dz_d;

  logic [NREQ-1:0] gnt_oh;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic            div_zero;

  logic [NREQ-1:0][DW-1:0]  lane_a, lane_b;
  logic [NREQ-1:0][OPW-1:0] lane_op;
  logic [DW-1:0]            sel_a, sel_b;
  logic [OPW-1:0]           sel_op;

  // Round-robin search starting just after the last served requester.
  // The inner loop keeps every index constant so NREQ need not be a power of 2.
  always_comb begin
    int idx;
    gnt_oh  = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!gnt_any && idx == j && req_valid[j]) begin
          gnt_any   = 1'b1;
          gnt_oh[j] = 1'b1;
          gnt_id    = IDW'(j);
        end
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    alu_req_arbiter_lane #(.DW(DW), .OPW(OPW)) u_lane (
      .gnt_i (gnt_oh[i]),
      .a_i   (req_a[i*DW +: DW]),
      .b_i   (req_b[i*DW +: DW]),
      .op_i  (req_op[i*OPW +: OPW]),
      .a_o   (lane_a[i]),
      .b_o   (lane_b[i]),
      .op_o  (lane_op[i])
    );
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_a  = sel_a  | lane_a[i];
      sel_b  = sel_b  | lane_b[i];
      sel_op = sel_op | lane_op[i];
    end
  end

  assign div_zero  = (alu_op_q == OPW'(3)) && (alu_b_q == '0);
  assign req_ready = (state_q == IDLE) ? gnt_oh : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_dz_d    = rsp_dz_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          alu_a_d  = sel_a;
          alu_b_d  = sel_b;
          alu_op_d = sel_op;
          id_d     = gnt_id;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_dz_d    = div_zero;
        rsp_data_d  = div_zero ? '1 : alu_out;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = rsp_id_q;  // served requester drops to last priority
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDW'(NREQ-1);
      id_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_dz_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_dz_q    <= rsp_dz_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_dz     = rsp_dz_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Testbench for alu_req_arbiter: a behavioural ALU closes the loop, per-requester
// op FIFOs drive the request side, and a monitor pops expected responses.
module tb_alu_req_arbiter;
  localparam int NREQ = 4, DW = 8, OPW = 4, IDW = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*DW-1:0]    req_a = '0, req_b = '0;
  logic [NREQ*OPW-1:0]   req_op = '0;
  logic [DW-1:0]         alu_a, alu_b, alu_out;
  logic [OPW-1:0]        alu_opcode;
  logic                  rsp_valid, rsp_ready = 1'b1, rsp_dz;
  logic [DW-1:0]         rsp_data;
  logic [IDW-1:0]        rsp_id;

  alu_req_arbiter #(.NREQ(NREQ), .DW(DW), .OPW(OPW), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_dz(rsp_dz)
  );

  always #5 clk = ~clk;

  // Shared ALU; divide by zero returns a junk value the DUT must override.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] op);
    case (op)
      4'h0: alu_f = a + b;
      4'h1: alu_f = a - b;
      4'h2: alu_f = a * b;
      4'h3: alu_f = (b == 8'h00) ? 8'h5A : a / b;
      4'h4: alu_f = a & b;
      4'h5: alu_f = a | b;
      4'h6: alu_f = a ^ b;
      4'h7: alu_f = ~a;
      4'h8: alu_f = a + 8'h01;
      4'h9: alu_f = a - 8'h01;
      4'hA: alu_f = a << 1;
      4'hB: alu_f = a >> 1;
      4'hC: alu_f = a;
      4'hD: alu_f = b;
      4'hE: alu_f = (a < b) ? a : b;
      default: alu_f = (a > b) ? a : b;
    endcase
  endfunction
  assign alu_out = alu_f(alu_a, alu_b, alu_opcode);

  typedef struct packed { logic [7:0] a; logic [7:0] b; logic [3:0] op; } op_t;
  typedef struct packed { logic [7:0] data; logic [1:0] id; logic dz; } rsp_t;

  op_t  rqm [NREQ][16];
  int   rq_wr [NREQ] = '{default: 0};
  int   rq_rd [NREQ] = '{default: 0};
  rsp_t exp_q[$];
  int   hs_cyc[$];
  logic [NREQ-1:0] hs = '0;
  int   cyc = 0;
  int   n_checks = 0, n_errors = 0;
  rsp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push_op(input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op);
    rqm[r][rq_wr[r] % 16] = '{a: a, b: b, op: op};
    rq_wr[r]++;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [1:0] id, input logic dz);
    exp_q.push_back('{data: d, id: id, dz: dz});
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Request driver: retire last cycle's handshakes, present FIFO heads,
  // then note which requesters will be accepted on the coming edge.
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) if (hs[i]) rq_rd[i]++;
    for (int i = 0; i < NREQ; i++) begin
      op_t e;
      e = rqm[i][rq_rd[i] % 16];
      req_valid[i]          = (rq_rd[i] != rq_wr[i]);
      req_a[i*DW +: DW]     = e.a;
      req_b[i*DW +: DW]     = e.b;
      req_op[i*OPW +: OPW]  = e.op;
    end
    #1;
    hs = rst_n ? (req_valid & req_ready) : '0;
  end

  // Response monitor: compare on every response handshake.
  always @(negedge clk) begin
    #1;
    if (rst_n && rsp_valid && rsp_ready) begin
      hs_cyc.push_back(cyc);
      chk("rsp_expected_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("rsp_data", rsp_data, mon_e.data);
        chk("rsp_id",   rsp_id,   mon_e.id);
        chk("rsp_dz",   rsp_dz,   mon_e.dz);
      end
    end
  end

  task automatic wait_drain(input string nm);
    bit done = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      tick();
      done = (exp_q.size() == 0) && !rsp_valid;
      for (int i = 0; i < NREQ; i++) if (rq_rd[i] != rq_wr[i]) done = 0;
    end
    chk(nm, done, 1);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
  endtask

  logic [31:0] snap_r, snap_a;
  bit          seen;

  initial begin
    // Reset state
    tick();
    chk("reset_alu_drive", {alu_a, alu_b, alu_opcode}, 0);
    chk("reset_rsp", {rsp_valid, rsp_data, rsp_id, rsp_dz}, 0);
    chk("reset_req_ready", req_ready, 0);
    @(negedge clk); rst_n = 1'b1; #2;

    // 1. single op and latency
    push_op(0, 8'h05, 8'h03, 4'h0); push_exp(8'h08, 2'd0, 1'b0);
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin tick(); seen = req_ready[0]; end
    chk("t1_grant_seen", seen, 1);
    chk("t1_grant_onehot", req_ready, 4'b0001);
    tick();  // ISSUE
    chk("t1_issue_no_rsp", rsp_valid, 0);
    chk("t1_issue_ready_low", req_ready, 0);
    chk("t1_alu_drive", {alu_a, alu_b, alu_opcode}, {8'h05, 8'h03, 4'h0});
    tick();  // RESP
    chk("t1_rsp_valid_lat2", rsp_valid, 1);
    wait_drain("t1_drain");

    // 2. all four valid, round-robin 0,1,2,3,0 at 3-cycle spacing
    do_reset();
    hs_cyc.delete();
    push_op(0, 8'h01, 8'h02, 4'h0); push_op(0, 8'h0A, 8'h50, 4'h5);
    push_op(1, 8'h10, 8'h01, 4'h1);
    push_op(2, 8'hF0, 8'h3C, 4'h4);
    push_op(3, 8'hFF, 8'h0F, 4'h6);
    push_exp(8'h03, 2'd0, 1'b0); push_exp(8'h0F, 2'd1, 1'b0);
    push_exp(8'h30, 2'd2, 1'b0); push_exp(8'hF0, 2'd3, 1'b0);
    push_exp(8'h5A, 2'd0, 1'b0);
    wait_drain("t2_drain");
    chk("t2_rsp_count", hs_cyc.size(), 5);
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("t2_spacing", hs_cyc[i] - hs_cyc[i-1], 3);

    // 3. divide by zero, then a normal divide
    push_op(2, 8'h10, 8'h00, 4'h3); push_exp(8'hFF, 2'd2, 1'b1);
    push_op(2, 8'h10, 8'h04, 4'h3); push_exp(8'h04, 2'd2, 1'b0);
    wait_drain("t3_drain");

    // 4. backpressure
    @(negedge clk); rsp_ready = 1'b0; #2;
    push_op(1, 8'h07, 8'h06, 4'h2); push_exp(8'h2A, 2'd1, 1'b0);
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin tick(); seen = rsp_valid; end
    chk("t4_rsp_seen", seen, 1);
    snap_r = {rsp_data, rsp_id, rsp_dz};
    snap_a = {alu_a, alu_b, alu_opcode};
    push_op(3, 8'h01, 8'h01, 4'h0); push_exp(8'h02, 2'd3, 1'b0);
    for (int t = 0; t < 10; t++) begin
      tick();
      chk("t4_rsp_stable", {rsp_valid, rsp_data, rsp_id, rsp_dz}, {1'b1, snap_r[10:0]});
      chk("t4_alu_stable", {alu_a, alu_b, alu_opcode}, snap_a);
      chk("t4_req_ready_low", req_ready, 0);
    end
    @(negedge clk); rsp_ready = 1'b1; #2;
    wait_drain("t4_drain");

    // 5. async reset during ISSUE discards the op
    push_op(2, 8'h33, 8'h11, 4'h0);
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin tick(); seen = req_ready[2]; end
    chk("t5_grant_seen", seen, 1);
    @(negedge clk);  // now in ISSUE
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_reset_alu_zero", {alu_a, alu_b, alu_opcode}, 0);
    chk("t5_reset_rsp_zero", {rsp_valid, rsp_data, rsp_id, rsp_dz}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #2;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("t5_no_rsp", rsp_valid, 0);
    end

    // 6. first grant after reset is requester 0; truncating ops
    push_op(1, 8'h20, 8'h10, 4'h2); push_exp(8'h00, 2'd1, 1'b0);
    push_op(0, 8'hFF, 8'h00, 4'h8); push_exp(8'h00, 2'd0, 1'b0);
    // Requester 0 must come first despite being pushed second.
    exp_q.delete();
    push_exp(8'h00, 2'd0, 1'b0); push_exp(8'h00, 2'd1, 1'b0);
    tick();
    chk("t6_first_grant_req0", req_ready, 4'b0001);
    wait_drain("t6_drain");

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
